// File: rtl/md_pkg.sv
// Shared types for the multiply/divide sequencer: op codes, FSM states, step count.
package md_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'b000,
    MD_MULTU = 3'b001,
    MD_DIV   = 3'b010,
    MD_DIVU  = 3'b011,
    MD_MTHI  = 3'b100,
    MD_MTLO  = 3'b101
  } mdop_t;

  typedef enum logic [1:0] {IDLE, RUN, FIX} mdstate_t;

  localparam int MD_STEPS = 32;

  // Two's-complement magnitude when the op treats the operand as signed.
  function automatic logic [31:0] mag32(input logic [31:0] x, input logic sgn);
    return (sgn && x[31]) ? -x : x;
  endfunction

endpackage

// File: rtl/md_iter.sv
// One iteration of the MDU datapath: shift-add multiply step, or (with MDU_DIV_EN)
// one restoring-divide step. acc holds the high/remainder half, qm the low/quotient half.
module md_iter
  import md_pkg::*;
(
`ifdef MDU_DIV_EN
  input  logic        is_div_i,
`endif
  input  logic [31:0] acc_i,
  input  logic [31:0] qm_i,
  input  logic [31:0] m_i,
  output logic [31:0] acc_o,
  output logic [31:0] qm_o
);
  logic [32:0] sum;
  assign sum = {1'b0, acc_i} + {1'b0, (qm_i[0] ? m_i : 32'd0)};

`ifdef MDU_DIV_EN
  logic [32:0] sh, diff;
  assign sh   = {acc_i, qm_i[31]};
  assign diff = sh - {1'b0, m_i};

  // diff[32] is the borrow: partial remainder smaller than divisor, so restore.
  always_comb begin
    if (is_div_i) begin
      acc_o = diff[32] ? sh[31:0] : diff[31:0];
      qm_o  = {qm_i[30:0], ~diff[32]};
    end else begin
      acc_o = sum[32:1];
      qm_o  = {sum[0], qm_i[31:1]};
    end
  end
`else
  assign acc_o = sum[32:1];
  assign qm_o  = {sum[0], qm_i[31:1]};
`endif

endmodule

// File: rtl/mdu_ctrl.sv
// Multiply/divide sequencer owning HI/LO; 32 RUN steps then a FIX sign-correction cycle.
// Define MDU_DIV_EN to build DIV/DIVU; otherwise they are ignored like reserved op codes.
module mdu_ctrl
  import md_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  mdop,
  input  logic [31:0] srca,
  input  logic [31:0] srcb,
  input  logic        hilo_rd,
  output logic        busy,
  output logic        stall,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  mdstate_t    state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] acc_q, acc_d, qm_q, qm_d, m_q, m_d, acc_n, qm_n;
  logic [31:0] hi_q, lo_q, a_mag, b_mag;
  logic [63:0] prod;
  logic        neg_lo_q, neg_lo_d;
  logic        idle, md_go, op_sgn, sa, sb, accept;
`ifdef MDU_DIV_EN
  logic        op_div, div_q, div_d, neg_hi_q, neg_hi_d;
`endif

  assign idle = (state_q == IDLE);

  always_comb begin
    md_go = 1'b0;
`ifdef MDU_DIV_EN
    op_div = 1'b0;
`endif
    case (mdop)
      MD_MULT, MD_MULTU: md_go = 1'b1;
`ifdef MDU_DIV_EN
      MD_DIV, MD_DIVU: begin
        md_go  = 1'b1;
        op_div = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  // Even op codes within mult/div are the signed variants.
  assign op_sgn = ~mdop[0];
  assign sa     = op_sgn & srca[31];
  assign sb     = op_sgn & srcb[31];
  assign a_mag  = mag32(srca, op_sgn);
  assign b_mag  = mag32(srcb, op_sgn);
  assign accept = start & idle & md_go;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (cnt_q == 5'(MD_STEPS - 1)) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != IDLE);
    done = (state_q == FIX);
  end

  assign stall = busy & (start | hilo_rd);

  md_iter u_iter (
`ifdef MDU_DIV_EN
    .is_div_i (div_q),
`endif
    .acc_i    (acc_q),
    .qm_i     (qm_q),
    .m_i      (m_q),
    .acc_o    (acc_n),
    .qm_o     (qm_n)
  );

  always_comb begin
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    qm_d     = qm_q;
    m_d      = m_q;
    neg_lo_d = neg_lo_q;
`ifdef MDU_DIV_EN
    div_d    = div_q;
    neg_hi_d = neg_hi_q;
`endif
    if (accept) begin
      cnt_d    = 5'd0;
      acc_d    = 32'd0;
      neg_lo_d = sa ^ sb;
      qm_d     = b_mag;
      m_d      = a_mag;
`ifdef MDU_DIV_EN
      div_d    = op_div;
      neg_hi_d = sa;
      if (op_div) begin
        qm_d = a_mag;
        m_d  = b_mag;
      end
`endif
    end else if (state_q == RUN) begin
      cnt_d = cnt_q + 5'd1;
      acc_d = acc_n;
      qm_d  = qm_n;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      qm_q     <= '0;
      m_q      <= '0;
      neg_lo_q <= 1'b0;
`ifdef MDU_DIV_EN
      div_q    <= 1'b0;
      neg_hi_q <= 1'b0;
`endif
    end else begin
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      qm_q     <= qm_d;
      m_q      <= m_d;
      neg_lo_q <= neg_lo_d;
`ifdef MDU_DIV_EN
      div_q    <= div_d;
      neg_hi_q <= neg_hi_d;
`endif
    end
  end

  assign prod = neg_lo_q ? -{acc_q, qm_q} : {acc_q, qm_q};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (state_q == FIX) begin
`ifdef MDU_DIV_EN
      if (div_q) begin
        lo_q <= neg_lo_q ? -qm_q : qm_q;
        hi_q <= neg_hi_q ? -acc_q : acc_q;
      end else
`endif
      begin
        hi_q <= prod[63:32];
        lo_q <= prod[31:0];
      end
    end else if (start & idle) begin
      if (mdop == MD_MTHI) hi_q <= srca;
      if (mdop == MD_MTLO) lo_q <= srca;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl: driver pushes reference results, monitor checks
// timing of busy/stall/done every cycle and HI/LO against a behavioural model.
module tb_mdu_ctrl;
  logic        clk = 1'b0, reset = 1'b1, start = 1'b0, hilo_rd = 1'b0;
  logic [2:0]  mdop = 3'd0;
  logic [31:0] srca = '0, srcb = '0;
  logic        busy, stall, done;
  logic [31:0] hi, lo;

  typedef struct { logic [31:0] hi; logic [31:0] lo; } exp_t;

  int     nvec = 0, nerr = 0, cyc = 0, acc = -1000;
  exp_t   sbq[$];
  bit     rd_rand = 1'b0;
`ifdef MDU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  mdu_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .mdop(mdop), .srca(srca), .srcb(srcb),
    .hilo_rd(hilo_rd), .busy(busy), .stall(stall), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask

  function automatic bit is_md(input logic [2:0] op);
    return (op <= 3'd1) || (DIV_EN && (op == 3'd2 || op == 3'd3));
  endfunction

  function automatic exp_t ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    longint sa_, sb_;
    logic [63:0] p;
    sa_ = longint'($signed(a));
    sb_ = longint'($signed(b));
    case (op)
      3'd0: begin p = sa_ * sb_; e.hi = p[63:32]; e.lo = p[31:0]; end
      3'd1: begin p = {32'd0, a} * {32'd0, b}; e.hi = p[63:32]; e.lo = p[31:0]; end
      3'd2: begin
        if (b == 0) begin e.lo = a[31] ? 32'd1 : 32'hFFFF_FFFF; e.hi = a; end
        else begin
          p = sa_ / sb_; e.lo = p[31:0];
          p = sa_ % sb_; e.hi = p[31:0];
        end
      end
      default: begin
        if (b == 0) begin e.lo = 32'hFFFF_FFFF; e.hi = a; end
        else begin e.lo = a / b; e.hi = a % b; end
      end
    endcase
    return e;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  task automatic tick();
    @(negedge clk);
    if (rd_rand) hilo_rd = 1'($urandom_range(0, 1));
  endtask

  // Presents an op and holds it until the unit is free, as a stalled EX would.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int k;
    start = 1'b1; mdop = op; srca = a; srcb = b;
    for (k = 0; k < 100 && busy; k++) tick();
    if (busy) begin
      nvec++; nerr++;
      $display("FAIL issue_timeout cyc=%0d got=busy want=idle", cyc);
    end else if (is_md(op)) begin
      acc = cyc;
      sbq.push_back(ref_op(op, a, b));
    end
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    for (k = 0; k < 100 && busy; k++) tick();
    if (busy) begin
      nvec++; nerr++;
      $display("FAIL idle_timeout cyc=%0d got=busy want=idle", cyc);
    end
  endtask

  // Monitor: owns the HI/LO model; pops the scoreboard on done.
  initial begin : monitor
    logic [31:0] mhi, mlo, mt_val;
    exp_t pe;
    bit   pend, mtv, eb;
    logic [2:0] mt_op;
    mhi = '0; mlo = '0; pend = 1'b0; mtv = 1'b0; mt_val = '0; mt_op = '0;
    pe.hi = '0; pe.lo = '0;
    forever begin
      @(negedge clk); #1;
      if (reset) begin
        sbq.delete(); pend = 1'b0; mtv = 1'b0; mhi = '0; mlo = '0;
      end
      eb = (cyc >= acc + 1) && (cyc <= acc + 33);
      chk("busy", 32'(busy), 32'(eb));
      chk("stall", 32'(stall), 32'(eb & (start | hilo_rd)));
      chk("done", 32'(done), 32'(cyc == acc + 33));
      if (pend) begin
        chk("res_hi", hi, pe.hi);
        chk("res_lo", lo, pe.lo);
        mhi = pe.hi; mlo = pe.lo; pend = 1'b0;
      end
      if (mtv) begin
        if (mt_op == 3'd4) mhi = mt_val; else mlo = mt_val;
        mtv = 1'b0;
      end
      if (done) begin
        if (sbq.size() == 0) begin
          nvec++; nerr++;
          $display("FAIL sb_empty cyc=%0d got=done want=no_done", cyc);
        end else begin
          pe = sbq.pop_front(); pend = 1'b1;
        end
      end
      chk("hi_hold", hi, mhi);
      chk("lo_hold", lo, mlo);
      if (!reset && start && !eb && (mdop == 3'd4 || mdop == 3'd5)) begin
        mtv = 1'b1; mt_op = mdop; mt_val = srca;
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
    $fatal(1);
  end

  initial begin : driver
    int a0;
    logic [31:0] h0, l0;
    repeat (3) tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    reset = 1'b0;
    tick();

    issue(3'd1, 32'hFFFF_FFFF, 32'h2); a0 = acc;
    wait_idle();
    chk("multu_cyc", 32'(cyc), 32'(a0 + 34));
    chk("multu_hi", hi, 32'h0000_0001);
    chk("multu_lo", lo, 32'hFFFF_FFFE);

    issue(3'd0, 32'hFFFF_FFFD, 32'd5); wait_idle();
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFF1);

`ifdef MDU_DIV_EN
    issue(3'd2, 32'hFFFF_FFF9, 32'd2); wait_idle();
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);
    issue(3'd3, 32'd10, 32'd0); wait_idle();
    chk("divz_lo", lo, 32'hFFFF_FFFF);
    chk("divz_hi", hi, 32'h0000_000A);
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF); wait_idle();
    chk("divovf_lo", lo, 32'h8000_0000);
    chk("divovf_hi", hi, 32'h0000_0000);
`else
    h0 = hi; l0 = lo;
    hilo_rd = 1'b1;
    issue(3'd3, 32'd10, 32'd3);
    repeat (5) tick();
    hilo_rd = 1'b0;
    chk("nodiv_busy", 32'(busy), 32'd0);
    chk("nodiv_hi", hi, h0);
    chk("nodiv_lo", lo, l0);
`endif

    issue(3'd1, 32'h0001_2345, 32'h0000_0FED); a0 = acc;
    while (cyc < a0 + 5) tick();
    hilo_rd = 1'b1;
    wait_idle();
    chk("rd_cyc", 32'(cyc), 32'(a0 + 34));
    chk("rd_stall_end", 32'(stall), 32'd0);
    hilo_rd = 1'b0;

    issue(3'd1, 32'hDEAD_BEEF, 32'h1234_5678); a0 = acc;
    issue(3'd0, 32'h8000_0000, 32'h8000_0000);
    chk("b2b_accept", 32'(acc), 32'(a0 + 34));
    wait_idle();
    chk("b2b_idle", 32'(cyc), 32'(a0 + 68));

    issue(3'd5, 32'h1234_5678, 32'd0);
    chk("mtlo_lo", lo, 32'h1234_5678);
    issue(3'd4, 32'hCAFE_F00D, 32'd0);
    chk("mthi_hi", hi, 32'hCAFE_F00D);

    issue(3'd0, 32'h0000_7777, 32'hFFFF_0001); a0 = acc;
    while (cyc < a0 + 10) tick();
    reset = 1'b1; acc = -1000;
    tick();
    reset = 1'b0;
    tick();
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    repeat (40) tick();

    rd_rand = 1'b1;
    repeat (40) begin
      issue(3'($urandom_range(0, 7)), pick(), pick());
      repeat ($urandom_range(0, 3)) tick();
    end
    rd_rand = 1'b0;
    hilo_rd = 1'b0;
    wait_idle();
    repeat (3) tick();
    chk("sb_drain", 32'(sbq.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
